// File: rtl/button_arbiter_pkg.sv
// button_arbiter_pkg
// Shared definitions for the two-player score front end: the arbiter state
// type and the default timing constants (50 MHz clock assumed).
package button_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD_A   = 2'd1,
    HOLD_B   = 2'd2,
    WAIT_REL = 2'd3
  } arb_state_t;

  localparam int DB_CYCLES_DEFAULT     = 500000;
  localparam int REPEAT_CYCLES_DEFAULT = 25000000;

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce
// Brings one active-low, asynchronous push button into the clk domain and
// debounces it. A level change is accepted only after the synchronised input
// has disagreed with the accepted level for DB_CYCLES consecutive cycles.
//
// Ports:
//   clk      system clock
//   rst      asynchronous, active-high reset (button reads as released)
//   btn_n    raw button pin, active low
//   pressed  debounced "button is pressed" level, active high
module btn_debounce #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic pressed
);

  localparam int CNT_W = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic sync1;
  logic sync2;
  logic level;
  logic [CNT_W-1:0] cnt;

  // Two-flop synchroniser; both stages reset to the released level so a
  // held button after reset is seen as a fresh press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
    end
  end

  // Stability counter. Any cycle where the input agrees with the accepted
  // level restarts the count, so short glitches never get through. The
  // counter never actually holds DB_CYCLES: the edge that would reach it
  // flips the level and clears the count instead.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= 1'b1;
      cnt   <= '0;
    end else if (sync2 == level) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      level <= sync2;
      cnt   <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign pressed = ~level;

endmodule

// File: rtl/button_arbiter.sv
// button_arbiter
// Front end for the two-player score display. Debounces buttons A, B and
// clear, then arbitrates them: the first player to press scores once and
// locks the other out until release; a simultaneous press scores nothing;
// clear always wins. All pulses are registered and one cycle wide.
//
// Optional feature (macro AUTO_REPEAT_EN): while a player's button stays
// held, the increment re-fires every REPEAT_CYCLES cycles.
//
// Ports:
//   clk        system clock
//   rst        asynchronous, active-high reset
//   btn_a_n    player A button, active low, asynchronous
//   btn_b_n    player B button, active low, asynchronous
//   clear_n    clear button, active low, asynchronous
//   inc_a      one-cycle pulse: increment score A
//   inc_b      one-cycle pulse: increment score B
//   clr_pulse  one-cycle pulse: reset both scores
//   lock_a     high while player A owns the buttons
//   lock_b     high while player B owns the buttons
module button_arbiter
  import button_arbiter_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
`ifdef AUTO_REPEAT_EN
  ,
  parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEFAULT
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_a_n,
  input  logic btn_b_n,
  input  logic clear_n,
  output logic inc_a,
  output logic inc_b,
  output logic clr_pulse,
  output logic lock_a,
  output logic lock_b
);

  logic pa;
  logic pb;
  logic pc;
  logic pc_q;

  arb_state_t state;
  arb_state_t state_next;
  logic inc_a_next;
  logic inc_b_next;
  logic clr_next;

`ifdef AUTO_REPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_CYCLES);
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

  logic [RPT_W-1:0] rpt_cnt;
  logic [RPT_W-1:0] rpt_next;
`endif

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_a (
    .clk     (clk),
    .rst     (rst),
    .btn_n   (btn_a_n),
    .pressed (pa)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_b (
    .clk     (clk),
    .rst     (rst),
    .btn_n   (btn_b_n),
    .pressed (pb)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_c (
    .clk     (clk),
    .rst     (rst),
    .btn_n   (clear_n),
    .pressed (pc)
  );

  // State and pulse registers. pc_q remembers last cycle's clear level so
  // that WAIT_REL can recognise a fresh clear press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pc_q      <= 1'b0;
      inc_a     <= 1'b0;
      inc_b     <= 1'b0;
      clr_pulse <= 1'b0;
`ifdef AUTO_REPEAT_EN
      rpt_cnt   <= '0;
`endif
    end else begin
      state     <= state_next;
      pc_q      <= pc;
      inc_a     <= inc_a_next;
      inc_b     <= inc_b_next;
      clr_pulse <= clr_next;
`ifdef AUTO_REPEAT_EN
      rpt_cnt   <= rpt_next;
`endif
    end
  end

  // Arbitration rules. Clear has top priority everywhere. Once a player
  // owns the buttons the other player's press is ignored, and if the owner
  // lets go while the other is still pressing we wait for everything to be
  // released so the late press can never score by itself.
  always_comb begin
    state_next = state;
    inc_a_next = 1'b0;
    inc_b_next = 1'b0;
    clr_next   = 1'b0;
`ifdef AUTO_REPEAT_EN
    rpt_next   = '0;
`endif
    case (state)
      IDLE: begin
        if (pc) begin
          state_next = WAIT_REL;
          clr_next   = 1'b1;
        end else if (pa && !pb) begin
          state_next = HOLD_A;
          inc_a_next = 1'b1;
        end else if (pb && !pa) begin
          state_next = HOLD_B;
          inc_b_next = 1'b1;
        end else if (pa && pb) begin
          state_next = WAIT_REL;
        end
      end
      HOLD_A: begin
        if (pc) begin
          state_next = WAIT_REL;
          clr_next   = 1'b1;
        end else if (!pa) begin
          state_next = pb ? WAIT_REL : IDLE;
        end else begin
`ifdef AUTO_REPEAT_EN
          if (rpt_cnt == RPT_LAST) begin
            inc_a_next = 1'b1;
          end else begin
            rpt_next = rpt_cnt + 1'b1;
          end
`endif
        end
      end
      HOLD_B: begin
        if (pc) begin
          state_next = WAIT_REL;
          clr_next   = 1'b1;
        end else if (!pb) begin
          state_next = pa ? WAIT_REL : IDLE;
        end else begin
`ifdef AUTO_REPEAT_EN
          if (rpt_cnt == RPT_LAST) begin
            inc_b_next = 1'b1;
          end else begin
            rpt_next = rpt_cnt + 1'b1;
          end
`endif
        end
      end
      WAIT_REL: begin
        if (pc && !pc_q) begin
          clr_next = 1'b1;
        end
        if (!pa && !pb && !pc) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign lock_a = (state == HOLD_A);
  assign lock_b = (state == HOLD_B);

endmodule

// File: tb/tb_button_arbiter.sv
// tb_button_arbiter
// Self-checking bench for button_arbiter with DB_CYCLES=4 (REPEAT_CYCLES=10
// when built with AUTO_REPEAT_EN). A behavioural model predicts the outputs
// every cycle; directed scenarios add latency and pulse-count checks, then a
// randomized phase exercises arbitrary button activity.
module tb_button_arbiter;

  localparam int DB = 4;
`ifdef AUTO_REPEAT_EN
  localparam int RPT = 10;
`endif

  localparam int M_IDLE = 0;
  localparam int M_A    = 1;
  localparam int M_B    = 2;
  localparam int M_WAIT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_a_n = 1'b1;
  logic btn_b_n = 1'b1;
  logic clear_n = 1'b1;
  logic inc_a;
  logic inc_b;
  logic clr_pulse;
  logic lock_a;
  logic lock_b;

  int tests_run = 0;
  int tests_failed = 0;
  bit chk_en = 1'b0;

  int cnt_a = 0;
  int cnt_b = 0;
  int cnt_c = 0;

  bit hist [3][DB+1];
  bit lvl [3];
  int mstate;
  bit m_pc_prev;
  bit e_inc_a;
  bit e_inc_b;
  bit e_clr;
  int held;

  button_arbiter #(
    .DB_CYCLES(DB)
`ifdef AUTO_REPEAT_EN
    ,
    .REPEAT_CYCLES(RPT)
`endif
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_a_n   (btn_a_n),
    .btn_b_n   (btn_b_n),
    .clear_n   (clear_n),
    .inc_a     (inc_a),
    .inc_b     (inc_b),
    .clr_pulse (clr_pulse),
    .lock_a    (lock_a),
    .lock_b    (lock_b)
  );

  always #5 clk = ~clk;

  // One comparison: count it, report it if it disagrees.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Reference model, reset half.
  function automatic void modelReset();
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i <= DB; i++) hist[b][i] = 1'b1;
      lvl[b] = 1'b1;
    end
    mstate    = M_IDLE;
    m_pc_prev = 1'b0;
    e_inc_a   = 1'b0;
    e_inc_b   = 1'b0;
    e_clr     = 1'b0;
    held      = 0;
  endfunction

  // Reference model, one clock edge. hist[b][i] is the pin as sampled i+1
  // edges ago; a new level is accepted once the DB most recent samples that
  // have made it through the two synchroniser stages all disagree with it.
  function automatic void modelStep(input bit pin_a, input bit pin_b, input bit pin_c);
    bit pa;
    bit pb;
    bit pc;
    bit pins [3];
    pins[0] = pin_a;
    pins[1] = pin_b;
    pins[2] = pin_c;
    pa = !lvl[0];
    pb = !lvl[1];
    pc = !lvl[2];
    e_inc_a = 1'b0;
    e_inc_b = 1'b0;
    e_clr   = 1'b0;
    if (mstate == M_IDLE) begin
      if (pc) begin
        mstate = M_WAIT; e_clr = 1'b1;
      end else if (pa && !pb) begin
        mstate = M_A; e_inc_a = 1'b1; held = 0;
      end else if (pb && !pa) begin
        mstate = M_B; e_inc_b = 1'b1; held = 0;
      end else if (pa && pb) begin
        mstate = M_WAIT;
      end
    end else if (mstate == M_A || mstate == M_B) begin
      bit own;
      bit other;
      own   = (mstate == M_A) ? pa : pb;
      other = (mstate == M_A) ? pb : pa;
      if (pc) begin
        mstate = M_WAIT; e_clr = 1'b1;
      end else if (!own) begin
        mstate = other ? M_WAIT : M_IDLE;
      end else begin
`ifdef AUTO_REPEAT_EN
        held++;
        if (held == RPT) begin
          held = 0;
          if (mstate == M_A) e_inc_a = 1'b1;
          else e_inc_b = 1'b1;
        end
`endif
      end
    end else begin
      if (pc && !m_pc_prev) e_clr = 1'b1;
      if (!pa && !pb && !pc) mstate = M_IDLE;
    end
    m_pc_prev = pc;
    for (int b = 0; b < 3; b++) begin
      bit all_diff;
      all_diff = 1'b1;
      for (int i = 1; i <= DB; i++) if (hist[b][i] == lvl[b]) all_diff = 1'b0;
      if (all_diff) lvl[b] = !lvl[b];
      for (int i = DB; i >= 1; i--) hist[b][i] = hist[b][i-1];
      hist[b][0] = pins[b];
    end
  endfunction

  // Model advances on the same edges as the design.
  always @(posedge clk or posedge rst) begin
    if (rst) modelReset();
    else modelStep(btn_a_n, btn_b_n, clear_n);
  end

  // Per-cycle comparison against the model, sampled mid-cycle, plus pulse
  // tallies used by the directed scenarios.
  always @(negedge clk) begin
    if (!rst) begin
      if (chk_en) begin
        checkOutput("cycle_outputs", 32'({inc_a, inc_b, clr_pulse, lock_a, lock_b}),
                    32'({e_inc_a, e_inc_b, e_clr, mstate == M_A, mstate == M_B}));
        checkOutput("pulse_exclusive", 32'($countones({inc_a, inc_b, clr_pulse}) <= 1), 32'd1);
      end
      if (inc_a) cnt_a++;
      if (inc_b) cnt_b++;
      if (clr_pulse) cnt_c++;
    end
  end

  // Drive the three pins, then let the given number of cycles pass.
  task automatic applyStimulus(input logic a_n, input logic b_n, input logic c_n,
                               input int cycles);
    btn_a_n = a_n;
    btn_b_n = b_n;
    clear_n = c_n;
    repeat (cycles) @(negedge clk);
  endtask

  // Assert reset just after a negedge and check outputs clear immediately.
  task automatic pulseReset(input string tag);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 checkOutput(tag, 32'({inc_a, inc_b, clr_pulse, lock_a, lock_b}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Cycles from the current negedge until inc_a is seen; 0 if never within 20.
  task automatic measureIncA(output int lat);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (inc_a) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin : watchdog
    #1000000;
    tests_failed++;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin : main
    int lat;
    int ba;
    int bb;
    int bc;

    pulseReset("reset_outputs");
    chk_en = 1'b1;

    // Single press of A: 7-edge latency, one pulse, lock while held.
    ba = cnt_a; bb = cnt_b;
    btn_a_n = 1'b0;
    measureIncA(lat);
    checkOutput("s1_latency", 32'(lat), 32'd7);
    checkOutput("s1_lock_a", 32'(lock_a), 32'd1);
    applyStimulus(0, 1, 1, 1);
    applyStimulus(1, 1, 1, 12);
    checkOutput("s1_inc_a_count", 32'(cnt_a - ba), 32'd1);
    checkOutput("s1_no_inc_b", 32'(cnt_b - bb), 32'd0);
    checkOutput("s1_unlocked", 32'({lock_a, lock_b}), 32'd0);

    // A held, B pressed and released, then A released: B never scores.
    bb = cnt_b;
    applyStimulus(0, 1, 1, 8);
    applyStimulus(0, 0, 1, 20);
    applyStimulus(0, 1, 1, 10);
    checkOutput("s2_lock_a_held", 32'(lock_a), 32'd1);
    applyStimulus(1, 1, 1, 12);
    checkOutput("s2_no_inc_b", 32'(cnt_b - bb), 32'd0);
    checkOutput("s2_unlocked", 32'({lock_a, lock_b}), 32'd0);
    applyStimulus(1, 0, 1, 8);
    checkOutput("s2_idle_b_scores", 32'(cnt_b - bb), 32'd1);
    applyStimulus(1, 1, 1, 12);

    // A released while B still held: no score until B re-presses.
    bb = cnt_b;
    applyStimulus(0, 1, 1, 8);
    applyStimulus(0, 0, 1, 10);
    applyStimulus(1, 0, 1, 10);
    checkOutput("s3_wait_locks", 32'({lock_a, lock_b}), 32'd0);
    checkOutput("s3_no_inc_b", 32'(cnt_b - bb), 32'd0);
    applyStimulus(1, 1, 1, 10);
    applyStimulus(1, 0, 1, 8);
    checkOutput("s3_repress_inc_b", 32'(cnt_b - bb), 32'd1);
    checkOutput("s3_lock_b", 32'(lock_b), 32'd1);
    applyStimulus(1, 1, 1, 12);

    // Tie: both fall together, nobody scores until both release.
    ba = cnt_a; bb = cnt_b;
    applyStimulus(0, 0, 1, 12);
    checkOutput("s4_tie_no_score", 32'((cnt_a - ba) + (cnt_b - bb)), 32'd0);
    checkOutput("s4_tie_locks", 32'({lock_a, lock_b}), 32'd0);
    applyStimulus(1, 1, 1, 10);
    applyStimulus(0, 1, 1, 8);
    checkOutput("s4_idle_after_tie", 32'(cnt_a - ba), 32'd1);
    applyStimulus(1, 1, 1, 12);

    // Short glitch on B, then clear during a hold of A.
    ba = cnt_a; bb = cnt_b; bc = cnt_c;
    applyStimulus(1, 0, 1, 3);
    applyStimulus(1, 1, 1, 12);
    checkOutput("s5_glitch_ignored", 32'(cnt_b - bb), 32'd0);
    applyStimulus(0, 1, 1, 8);
    applyStimulus(0, 1, 0, 10);
    applyStimulus(0, 1, 1, 10);
    checkOutput("s5_clr_count", 32'(cnt_c - bc), 32'd1);
    checkOutput("s5_lock_a_dropped", 32'(lock_a), 32'd0);
    checkOutput("s5_inc_a_count", 32'(cnt_a - ba), 32'd1);
    applyStimulus(1, 1, 1, 12);

    // Reset in the middle of a hold, then the still-held button re-scores.
    applyStimulus(0, 1, 1, 10);
    pulseReset("rst_mid_hold_outputs");
    measureIncA(lat);
    checkOutput("rst_rehold_latency", 32'(lat), 32'd7);
    applyStimulus(1, 1, 1, 12);

`ifdef AUTO_REPEAT_EN
    // Auto-repeat: pulses at acceptance +0, +10, +20, +30.
    begin
      int edges[$];
      btn_a_n = 1'b0;
      for (int k = 1; k <= 42; k++) begin
        @(negedge clk);
        if (inc_a) edges.push_back(k);
      end
      checkOutput("rpt_pulse_count", 32'(edges.size()), 32'd4);
      for (int i = 0; i < edges.size() && i < 4; i++)
        checkOutput("rpt_pulse_edge", 32'(edges[i]), 32'(7 + 10 * i));
      pulseReset("rpt_rst_outputs");
      applyStimulus(1, 1, 1, 12);
    end
`endif

    // Randomized activity, checked every cycle by the model.
    for (int n = 0; n < 300; n++) begin
      logic a_n;
      logic b_n;
      logic c_n;
      a_n = 1'($urandom_range(0, 1));
      b_n = 1'($urandom_range(0, 1));
      c_n = ($urandom_range(0, 9) < 2) ? 1'b0 : 1'b1;
      applyStimulus(a_n, b_n, c_n, int'($urandom_range(1, 12)));
    end
    applyStimulus(1, 1, 1, 15);
    checkOutput("final_unlocked", 32'({lock_a, lock_b}), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
